// File: rtl/bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
// Holds the sequencing state encoding and the default datapath width.
package bit_serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } serial_state_e;

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bw_in, with the borrow produced by this bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bw_in,
  output logic d,
  output logic bw_out
);

  assign d      = a ^ b ^ bw_in;
  assign bw_out = (~a & b) | (~a & bw_in) | (b & bw_in);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle LSB first, result and final borrow
// are published together on the cycle the sequencer enters DONE.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bw_in,
  input  logic             load,
  output logic [WIDTH-1:0] diff,
  output logic             bw_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             bw_out_q, bw_out_d;
  logic             fs_d_s;
  logic             fs_bw_s;

  full_subtractor u_cell (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bw_in  (bw_q),
    .d      (fs_d_s),
    .bw_out (fs_bw_s)
  );

  // Sequencer and datapath next-state; diff/bw_out only move on the last bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    bw_out_d = bw_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bw_d    = bw_in;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = {fs_d_s, res_q[WIDTH-1:1]};
        bw_d   = fs_bw_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d    = {CNT_W{1'b0}};
          diff_d   = res_d;
          bw_out_d = fs_bw_s;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      bw_q     <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bw_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      bw_out_q <= bw_out_d;
    end
  end

  assign diff   = diff_q;
  assign bw_out = bw_out_q;
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);

endmodule
